// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm sequencer: FSM state encoding,
// BCD time layout and default timing values.
package alarm_pkg;

  typedef enum logic [1:0] {IDLE, RINGING, SNOOZED} alarm_state_t;

  localparam int TIME_W = 24;

  typedef struct packed {
    logic [TIME_W/3-1:0] hh;
    logic [TIME_W/3-1:0] mm;
    logic [TIME_W/3-1:0] ss;
  } bcd_time_t;

  localparam int DEFAULT_RING_SECONDS   = 60;
  localparam int DEFAULT_SNOOZE_SECONDS = 300;
  localparam int CNT_W                  = 12;
  localparam int SNZ_USED_W             = 4;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alarm_priority_encoder.sv
// Combinational lowest-index-first priority encoder over the pending alarm vector.
module alarm_priority_encoder
  import alarm_pkg::*;
#(
  parameter  int NUM_ALARMS = 4,
  localparam int IDX_W      = idx_width(NUM_ALARMS)
) (
  input  logic [NUM_ALARMS-1:0] req,
  output logic [IDX_W-1:0]      idx,
  output logic                  valid
);

  // Scanning downwards lets the lowest set bit overwrite any higher one.
  always_comb begin
    idx   = '0;
    valid = |req;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/alarm_sequencer.sv
// Alarm ringing engine: per-second match against alarm slots, pending queue,
// ring/snooze/timeout FSM, hourly chime. Snooze support built only with ALARM_SNOOZE_EN.
module alarm_sequencer
  import alarm_pkg::*;
#(
  parameter  int NUM_ALARMS     = 4,
  parameter  int RING_SECONDS   = DEFAULT_RING_SECONDS,
  parameter  int SNOOZE_SECONDS = DEFAULT_SNOOZE_SECONDS,
  parameter  int MAX_SNOOZE     = 3,
  localparam int IDX_W          = idx_width(NUM_ALARMS)
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic                             tick,
  input  bcd_time_t                        time_data,
  input  bcd_time_t [NUM_ALARMS-1:0]       alarm_data,
  input  logic      [NUM_ALARMS-1:0]       alarm_enable,
  input  logic      [NUM_ALARMS-1:0]       alarm_once,
  input  logic                             dismiss,
  input  logic                             snooze,
  output logic                             ringing,
  output logic      [IDX_W-1:0]            ring_index,
  output logic                             snoozed,
  output logic      [NUM_ALARMS-1:0]       disable_req,
  output logic                             oclock
);

  alarm_state_t          state, state_d;
  logic [IDX_W-1:0]      idx_d, sel_idx;
  logic [CNT_W-1:0]      ring_cnt, ring_cnt_d;
  logic [NUM_ALARMS-1:0] pending, pending_d, match, served_mask, take_mask, disable_d;
  logic                  sel_valid;

`ifdef ALARM_SNOOZE_EN
  logic [CNT_W-1:0]      snz_cnt, snz_cnt_d;
  logic [SNZ_USED_W-1:0] snooze_used, snooze_used_d;
`else
  localparam int unused_snooze_cfg = SNOOZE_SECONDS + MAX_SNOOZE + SNZ_USED_W;
  logic unused_snooze;
  assign unused_snooze = snooze;
`endif

  always_comb begin
    for (int i = 0; i < NUM_ALARMS; i++) begin
      match[i] = alarm_enable[i] && (time_data == alarm_data[i]);
    end
  end

  alarm_priority_encoder #(.NUM_ALARMS(NUM_ALARMS)) u_prio (
    .req   (pending),
    .idx   (sel_idx),
    .valid (sel_valid)
  );

  // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d     = state;
    idx_d       = ring_index;
    ring_cnt_d  = ring_cnt;
    disable_d   = '0;
    take_mask   = '0;
    served_mask = '0;
`ifdef ALARM_SNOOZE_EN
    snz_cnt_d     = snz_cnt;
    snooze_used_d = snooze_used;
`endif
    if (state != IDLE) served_mask[ring_index] = 1'b1;

    case (state)
      IDLE: begin
        if (sel_valid) begin
          state_d            = RINGING;
          idx_d              = sel_idx;
          take_mask[sel_idx] = 1'b1;
          ring_cnt_d         = CNT_W'(RING_SECONDS);
`ifdef ALARM_SNOOZE_EN
          snooze_used_d      = '0;
`endif
        end
      end
      RINGING: begin
        if (!alarm_enable[ring_index]) begin
          state_d = IDLE;
        end else if (dismiss) begin
          state_d               = IDLE;
          disable_d[ring_index] = alarm_once[ring_index];
`ifdef ALARM_SNOOZE_EN
        end else if (snooze && (snooze_used < SNZ_USED_W'(MAX_SNOOZE))) begin
          state_d       = SNOOZED;
          snz_cnt_d     = CNT_W'(SNOOZE_SECONDS);
          snooze_used_d = snooze_used + 1'b1;
`endif
        end else if (tick) begin
          ring_cnt_d = ring_cnt - 1'b1;
          if (ring_cnt_d == '0) begin
            state_d               = IDLE;
            disable_d[ring_index] = alarm_once[ring_index];
          end
        end
      end
`ifdef ALARM_SNOOZE_EN
      SNOOZED: begin
        if (!alarm_enable[ring_index]) begin
          state_d = IDLE;
        end else if (dismiss) begin
          state_d               = IDLE;
          disable_d[ring_index] = alarm_once[ring_index];
        end else if (tick) begin
          snz_cnt_d = snz_cnt - 1'b1;
          if (snz_cnt_d == '0) begin
            state_d    = RINGING;
            ring_cnt_d = CNT_W'(RING_SECONDS);
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    // A slot being served, or taken this cycle, must not be re-queued by its own match.
    pending_d = ((pending & ~take_mask) |
                 (tick ? (match & ~served_mask & ~take_mask) : '0)) & alarm_enable;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= IDLE;
      ring_index  <= '0;
      ring_cnt    <= '0;
      pending     <= '0;
      disable_req <= '0;
      oclock      <= 1'b0;
`ifdef ALARM_SNOOZE_EN
      snz_cnt     <= '0;
      snooze_used <= '0;
`endif
    end else begin
      state       <= state_d;
      ring_index  <= idx_d;
      ring_cnt    <= ring_cnt_d;
      pending     <= pending_d;
      disable_req <= disable_d;
      oclock      <= tick && (time_data.mm == '0) && (time_data.ss == '0);
`ifdef ALARM_SNOOZE_EN
      snz_cnt     <= snz_cnt_d;
      snooze_used <= snooze_used_d;
`endif
    end
  end

  assign ringing = (state == RINGING);
`ifdef ALARM_SNOOZE_EN
  assign snoozed = (state == SNOOZED);
`else
  assign snoozed = 1'b0;
`endif

endmodule

// File: tb/tb_alarm_sequencer.sv
// Self-checking bench for alarm_sequencer: table-driven match vectors with a
// ring-start scoreboard, plus hand sequences for queueing, timeout, snooze and reset.
module tb_alarm_sequencer;
  import alarm_pkg::*;

  localparam int NA = 4;

  logic             clock = 1'b0;
  logic             reset_n;
  logic             tick;
  bcd_time_t        time_data;
  bcd_time_t [NA-1:0] alarm_data;
  logic [NA-1:0]    alarm_enable;
  logic [NA-1:0]    alarm_once;
  logic             dismiss;
  logic             snooze;
  logic             ringing;
  logic [1:0]       ring_index;
  logic             snoozed;
  logic [NA-1:0]    disable_req;
  logic             oclock;

  alarm_sequencer #(
    .NUM_ALARMS     (NA),
    .RING_SECONDS   (3),
    .SNOOZE_SECONDS (2),
    .MAX_SNOOZE     (1)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .tick         (tick),
    .time_data    (time_data),
    .alarm_data   (alarm_data),
    .alarm_enable (alarm_enable),
    .alarm_once   (alarm_once),
    .dismiss      (dismiss),
    .snooze       (snooze),
    .ringing      (ringing),
    .ring_index   (ring_index),
    .snoozed      (snoozed),
    .disable_req  (disable_req),
    .oclock       (oclock)
  );

  always #5 clock = ~clock;

  int passed = 0;
  int total  = 0;
  int dis_pulses = 0;

  always @(negedge clock) begin
    if (disable_req != '0) dis_pulses <= dis_pulses + 1;
  end

  typedef struct {
    logic       ring;
    logic [1:0] idx;
  } exp_t;

  exp_t sb_q[$];

  typedef struct {
    bcd_time_t  t;
    logic [3:0] en;
    logic [3:0] once;
    logic       ring;
    logic [1:0] idx;
    logic       ock;
    logic [3:0] dis;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_tick(input bcd_time_t t);
    time_data = t;
    tick      = 1'b1;
    step();
    tick      = 1'b0;
  endtask

  task automatic pulse_dismiss();
    dismiss = 1'b1;
    step();
    dismiss = 1'b0;
  endtask

  task automatic pulse_snooze();
    snooze = 1'b1;
    step();
    snooze = 1'b0;
  endtask

  task automatic check_sb(input string name);
    exp_t e;
    if (sb_q.size() == 0) begin
      total++;
      $display("FAIL %s: scoreboard empty, got ringing=%0b", name, ringing);
    end else begin
      e = sb_q.pop_front();
      check({name, "_ringing"}, ringing, e.ring);
      if (e.ring) check({name, "_index"}, ring_index, e.idx);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int p0;
    vecs[0] = '{24'h073000, 4'hF, 4'h0, 1'b1, 2'd1, 1'b0, 4'h0};
    vecs[1] = '{24'h073001, 4'hF, 4'h0, 1'b0, 2'd0, 1'b0, 4'h0};
    vecs[2] = '{24'h235959, 4'hF, 4'h8, 1'b1, 2'd3, 1'b0, 4'h8};
    vecs[3] = '{24'h073000, 4'hD, 4'h0, 1'b0, 2'd0, 1'b0, 4'h0};
    vecs[4] = '{24'h090000, 4'hF, 4'h0, 1'b0, 2'd0, 1'b1, 4'h0};
    vecs[5] = '{24'h235959, 4'hF, 4'h0, 1'b1, 2'd3, 1'b0, 4'h0};
    vecs[6] = '{24'h120000, 4'h0, 4'h0, 1'b0, 2'd0, 1'b1, 4'h0};

    reset_n       = 1'b0;
    tick          = 1'b0;
    time_data     = 24'h000000;
    alarm_data[0] = 24'h120000;
    alarm_data[1] = 24'h073000;
    alarm_data[2] = 24'h120000;
    alarm_data[3] = 24'h235959;
    alarm_enable  = '0;
    alarm_once    = '0;
    dismiss       = 1'b0;
    snooze        = 1'b0;
    step();
    step();
    check("rst_ringing", ringing, 1'b0);
    check("rst_snoozed", snoozed, 1'b0);
    check("rst_index", ring_index, 2'd0);
    check("rst_disable", disable_req, 4'h0);
    check("rst_oclock", oclock, 1'b0);
    reset_n = 1'b1;
    step();

    // Table-driven match vectors
    foreach (vecs[i]) begin
      alarm_enable = vecs[i].en;
      alarm_once   = vecs[i].once;
      do_tick(vecs[i].t);
      check($sformatf("v%0d_oclock", i), oclock, vecs[i].ock);
      check($sformatf("v%0d_early", i), ringing, 1'b0);
      sb_q.push_back('{vecs[i].ring, vecs[i].idx});
      step();
      check_sb($sformatf("v%0d", i));
      if (vecs[i].ring) begin
        pulse_dismiss();
        check($sformatf("v%0d_disable", i), disable_req, vecs[i].dis);
        check($sformatf("v%0d_stop", i), ringing, 1'b0);
        step();
        check($sformatf("v%0d_idle", i), ringing, 1'b0);
        check($sformatf("v%0d_dis_clr", i), disable_req, 4'h0);
      end
    end

    // Two slots at noon: served in index order, one-shot slot 2 requests disable
    alarm_enable = 4'b0101;
    alarm_once   = 4'b0100;
    do_tick(24'h120000);
    check("noon_oclock", oclock, 1'b1);
    sb_q.push_back('{1'b1, 2'd0});
    step();
    check_sb("noon_first");
    check("noon_oclock_clr", oclock, 1'b0);
    pulse_dismiss();
    check("noon_first_stop", ringing, 1'b0);
    check("noon_first_dis", disable_req, 4'h0);
    sb_q.push_back('{1'b1, 2'd2});
    step();
    check_sb("noon_second");
    pulse_dismiss();
    check("noon_second_dis", disable_req, 4'b0100);
    step();
    check("noon_dis_pulse", disable_req, 4'h0);
    check("noon_idle", ringing, 1'b0);

    // Ring timeout after 3 ticks on a one-shot slot
    alarm_enable = 4'hF;
    alarm_once   = 4'h8;
    do_tick(24'h235959);
    step();
    check("to_ringing", ringing, 1'b1);
    do_tick(24'h010203);
    do_tick(24'h010204);
    check("to_still", ringing, 1'b1);
    do_tick(24'h010205);
    check("to_expired", ringing, 1'b0);
    check("to_disable", disable_req, 4'h8);
    step();
    check("to_dis_clr", disable_req, 4'h0);

    // Snooze behaviour
    alarm_once = 4'h0;
    do_tick(24'h073000);
    step();
    check("snz_ring", ringing, 1'b1);
`ifdef ALARM_SNOOZE_EN
    pulse_snooze();
    check("snz_snoozed", snoozed, 1'b1);
    check("snz_not_ring", ringing, 1'b0);
    do_tick(24'h010203);
    check("snz_hold", snoozed, 1'b1);
    do_tick(24'h010204);
    check("snz_rering", ringing, 1'b1);
    check("snz_rering_s", snoozed, 1'b0);
    pulse_snooze();
    check("snz_limit_ring", ringing, 1'b1);
    check("snz_limit_s", snoozed, 1'b0);
    dismiss = 1'b1;
    snooze  = 1'b1;
    step();
    dismiss = 1'b0;
    snooze  = 1'b0;
    check("snz_both_ring", ringing, 1'b0);
    check("snz_both_s", snoozed, 1'b0);
`else
    pulse_snooze();
    check("snz_off_ring", ringing, 1'b1);
    check("snz_off_s", snoozed, 1'b0);
    step();
    check("snz_off_hold", ringing, 1'b1);
    pulse_dismiss();
    check("snz_off_stop", ringing, 1'b0);
`endif
    step();

    // Enable dropped while ringing: back to idle, no disable request
    alarm_once = 4'h8;
    do_tick(24'h235959);
    step();
    check("en_ring", ringing, 1'b1);
    check("en_index", ring_index, 2'd3);
    p0 = dis_pulses;
    alarm_enable = 4'b0111;
    step();
    check("en_idle", ringing, 1'b0);
    step();
    check("en_no_disable", dis_pulses - p0, 0);
    alarm_enable = 4'hF;
    alarm_once   = 4'h0;

    // Reset in the middle of a ring (snoozed when the feature is built)
    do_tick(24'h073000);
    step();
    check("rst2_ring", ringing, 1'b1);
`ifdef ALARM_SNOOZE_EN
    pulse_snooze();
    check("rst2_snoozed", snoozed, 1'b1);
`endif
    reset_n = 1'b0;
    step();
    check("rst2_ringing", ringing, 1'b0);
    check("rst2_snoozed_0", snoozed, 1'b0);
    check("rst2_index", ring_index, 2'd0);
    check("rst2_disable", disable_req, 4'h0);
    check("rst2_oclock", oclock, 1'b0);
    reset_n = 1'b1;
    step();
    step();
    check("rst2_stays_idle", ringing, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
